circ_buffer_arbiter: RTL and testbench
======================================

# circ_buffer_arbiter

Round-robin write arbiter and pointer controller for a shared circular buffer (default 16 × 8 bit). Multiple producers compete for the single write port through valid/ready handshakes. One consumer pops entries in FIFO order. Write and read pointers are modulo counters that wrap at DEPTH-1. The block is the controller that sequences the circular-buffer datapath and shares it between requesters.

## Interface
- NUM_REQ, 2: number of producers (2..8)
- DATA_W, 8: entry width in bits
- DEPTH, 16: buffer entries; need not be a power of two
- PTR_W, 4: pointer width, equal to ceil(log2(DEPTH))

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high (one clock; synchronous active-high reset is already decided)
- req_valid  in  NUM_REQ  producer i has data
- req_data  in  NUM_REQ*DATA_W  producer i data, slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- grant_id  out  3  index of the last accepted producer, registered
- rd_en  in  1  pop request
- rd_data  out  DATA_W  popped entry, registered
- rd_valid  out  1  rd_data valid, one-cycle pulse
- count  out  PTR_W+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- flush  in  1  synchronous clear of pointers and count
- drop_cnt  out  8  saturating count of denied-request cycles (see Configuration)

## Operation
- Arbitration: round-robin. The search starts at rr_last+1 mod NUM_REQ, and the first asserted req_valid wins.
- req_ready is one-hot and combinational from req_valid, rr_last and full. It is all-zero when full or flush.
- A write is accepted when req_valid[i] && req_ready[i]:
  - mem[wr_ptr] <= data
  - wr_ptr advances modulo DEPTH (DEPTH-1 -> 0)
  - rr_last <= i and grant_id <= i
- rr_last updates only on an accepted write. Idle cycles keep it unchanged.
- A pop is accepted when rd_en && !empty:
  - rd_data <= mem[rd_ptr] and rd_valid <= 1
  - rd_ptr advances modulo DEPTH
- rd_en while empty is ignored: rd_valid=0 and rd_data holds.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Write and pop in the same cycle are both legal whenever the individual conditions hold.
- Full and rd_en in the same cycle: the pop proceeds, no write is granted that cycle (no bypass). req_ready reasserts the next cycle.
- Empty and write in the same cycle: the pop is ignored (no fall-through). Data becomes poppable the next cycle.
- flush:
  - wr_ptr, rd_ptr and count go to 0, and rd_valid goes to 0.
  - No write or pop is accepted that cycle.
  - Memory contents and rr_last are retained.
  - flush takes priority over all other activity.
- All pointer and count arithmetic uses explicit compare-and-wrap, never bit truncation.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, grant_id=0, drop_cnt=0, rr_last=NUM_REQ-1 (requester 0 wins first).
- Write: the handshake completes in the same cycle. Entry storage is visible to a pop on the next cycle.
- Read latency: 1 cycle. rd_data and rd_valid are registered on the edge that accepts rd_en.
- count, full and empty are registered and reflect the state after the edge.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - Buffer contents are don't-care afterwards.
  - req_ready is all-zero while rst=1.
- Sustained throughput: 1 write and 1 pop per cycle.

## Configuration
- Macro: CBA_DROP_CNT_EN.
- Defined: drop_cnt increments on each cycle with (|req_valid) && full && !flush. It saturates at 255 and clears on rst or flush.
- Undefined: the counter logic is omitted and drop_cnt is tied to 0.

## Structure
- Shared package cba_pkg holds:
  - default constants: CBA_DEPTH=16, CBA_DATA_W=8, CBA_NUM_REQ=2
  - the rr_next function (round-robin search)
  - the ptr_inc function (modulo increment)
- One sub-module is used: cba_mem, a DEPTH × DATA_W register array with a synchronous write port and a registered read port. The controller instantiates it.

## Test plan
- Reset, then one producer writes 0x11..0x1F and 0x20 (16 writes). Required: full=1 and count=16 after the 16th; the 17th request sees req_ready=0.
- Both producers hold valid constantly on an empty buffer. Required: grants alternate 0,1,0,1 starting with 0, and pops return the data interleaved in the same order.
- Fill to full, then assert rd_en and req_valid together. Required: the pop returns the oldest entry, no grant that cycle, a grant the next cycle, count 16 -> 15 -> 16.
- Write 20 entries while popping continuously. Required: wr_ptr and rd_ptr wrap 15 -> 0, and data order is preserved across the wrap.
- Pop on empty. Required: rd_valid=0. Then write 0xA5 and pop in the same cycle: the pop is ignored, and the next-cycle pop returns 0xA5.
- With CBA_DROP_CNT_EN defined, hold full with req_valid=1 for 300 cycles. Required: drop_cnt=255. Then assert flush: drop_cnt=0, count=0, empty=1.

Source files
------------

// File: rtl/circ_buffer_arbiter_pkg.sv
// Shared constants and helpers for the circular-buffer arbiter: round-robin search and modulo pointer increment.
// Pure combinational functions, zero latency; no flow control of their own.
package cba_pkg;
    localparam int CBA_DEPTH   = 16;
    localparam int CBA_DATA_W  = 8;
    localparam int CBA_NUM_REQ = 2;
    localparam int CBA_MAX_REQ = 8;
    localparam int CBA_ID_W    = 3;

    typedef struct packed {
        logic                hit;
        logic [CBA_ID_W-1:0] idx;
    } rr_pick_t;

    // Walk from last+1 upward; scanning k downward lets the nearest candidate overwrite farther ones.
    function automatic rr_pick_t rr_next(input logic [CBA_MAX_REQ-1:0] valid,
                                         input logic [CBA_ID_W-1:0]    last,
                                         input int                     num_req);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = CBA_MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                cand = int'(last) + k;
                if (cand >= num_req) cand = cand - num_req;
                if (valid[cand[CBA_ID_W-1:0]]) begin
                    pick.hit = 1'b1;
                    pick.idx = cand[CBA_ID_W-1:0];
                end
            end
        end
        return pick;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/circ_buffer_arbiter_mem.sv
// Entry storage for the circular buffer: synchronous write port, registered read port.
// Read data appears one cycle after rd_en; no backpressure, the controller guarantees legal accesses.
module cba_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/circ_buffer_arbiter.sv
// Round-robin write arbiter and pointer control for a shared circular buffer; CBA_DROP_CNT_EN enables drop_cnt.
// Write accepted same cycle, pop data registered one cycle later; req_ready drops to zero when full, flushing or in reset.
module circ_buffer_arbiter
    import cba_pkg::*;
#(
    parameter int NUM_REQ = CBA_NUM_REQ,
    parameter int DATA_W  = CBA_DATA_W,
    parameter int DEPTH   = CBA_DEPTH,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [2:0]                grant_id,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic [PTR_W:0]            count,
    output logic                      full,
    output logic                      empty,
    input  logic                      flush,
    output logic [7:0]                drop_cnt
);
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        rr_last;
    rr_pick_t          pick;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_data;
    logic [PTR_W:0]    count_nxt;

    always_comb begin
        pick      = rr_next(CBA_MAX_REQ'(req_valid), rr_last, NUM_REQ);
        req_ready = '0;
        if (!rst && !full && !flush && pick.hit) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (int'(pick.idx) == i);
            end
        end
    end

    assign wr_fire = |(req_valid & req_ready);
    assign rd_fire = rd_en && !empty && !flush;
    assign wr_data = req_data[int'(pick.idx)*DATA_W +: DATA_W];

    always_comb begin
        count_nxt = count;
        if (flush)                   count_nxt = '0;
        else if (wr_fire && !rd_fire) count_nxt = count + 1'b1;
        else if (!wr_fire && rd_fire) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            grant_id <= '0;
            rr_last  <= 3'(NUM_REQ - 1);
        end else begin
            count    <= count_nxt;
            full     <= (count_nxt == (PTR_W+1)'(DEPTH));
            empty    <= (count_nxt == '0);
            rd_valid <= rd_fire;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_fire) begin
                    wr_ptr   <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
                    rr_last  <= pick.idx;
                    grant_id <= pick.idx;
                end
                if (rd_fire) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
            end
        end
    end

    cba_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef CBA_DROP_CNT_EN
    // Counts cycles where a producer wanted in but the buffer was full.
    always_ff @(posedge clk) begin
        if (rst || flush)
            drop_cnt <= '0;
        else if ((|req_valid) && full && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_circ_buffer_arbiter.sv
// Scoreboard bench for circ_buffer_arbiter: reference model predicts grants, occupancy and popped data.
// One task call per clock; outputs sampled 1 time unit after the rising edge.
module tb_circ_buffer_arbiter;
    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [2:0]       grant_id;
    logic             rd_en;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic [PW:0]      count;
    logic             full;
    logic             empty;
    logic             flush;
    logic [7:0]       drop_cnt;

    circ_buffer_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .flush     (flush),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] din [NR];
    logic [7:0] sb [$];
    int         m_rr;
    int         m_gid;
    int         m_drop;
    logic [7:0] m_rd_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '1; rd_en = 1'b0; flush = 1'b0; req_data = '0;
        #1;
        check("ready_in_rst", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete(); m_rr = NR - 1; m_gid = 0; m_drop = 0; m_rd_data = '0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    task automatic cycle(input logic [NR-1:0] v, input logic re, input logic fl);
        logic [NR-1:0] exp_rdy;
        int            g;
        int            occ;
        logic          rd;
        req_valid = v; rd_en = re; flush = fl;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = din[i];
        #1;
        occ = sb.size();
        exp_rdy = '0; g = -1;
        if (!fl && occ < DEPTH)
            for (int k = 1; k <= NR; k++)
                if (g < 0 && v[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        rd = re && occ > 0 && !fl;
`ifdef CBA_DROP_CNT_EN
        if (fl) m_drop = 0;
        else if ((|v) && occ == DEPTH && m_drop < 255) m_drop++;
`endif
        if (rd) m_rd_data = sb.pop_front();
        if (g >= 0) begin sb.push_back(din[g]); m_rr = g; m_gid = g; end
        if (fl) sb.delete();
        @(posedge clk); #1;
        check("rd_valid", 32'(rd_valid), 32'(rd));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        check("count", 32'(count), 32'(sb.size()));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
        check("empty", 32'(empty), 32'(sb.size() == 0));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    initial begin
        din[0] = '0; din[1] = '0;
        do_reset();

        // Single producer fills the buffer, 17th request must be refused.
        for (int i = 0; i < 16; i++) begin din[0] = 8'(8'h11 + i); cycle(2'b01, 1'b0, 1'b0); end
        check("full_after_16", 32'(full), 32'd1);
        check("count_after_16", 32'(count), 32'd16);
        cycle(2'b01, 1'b0, 1'b0);
        // Full with pop and request together: pop only, grant follows.
        din[0] = 8'h30;
        cycle(2'b01, 1'b1, 1'b0);
        check("pop_oldest", 32'(rd_data), 32'h11);
        check("count_15", 32'(count), 32'd15);
        cycle(2'b01, 1'b0, 1'b0);
        check("count_16_again", 32'(count), 32'd16);
        // Flush with rd_en asserted: nothing popped, state cleared.
        cycle(2'b01, 1'b1, 1'b1);

        // Both producers always valid from reset: alternate starting at 0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            din[0] = 8'(8'hA0 + k); din[1] = 8'(8'hB0 + k);
            cycle(2'b11, 1'b1, 1'b0);
            check("rr_alternate", 32'(grant_id), 32'(k % 2));
        end
        for (int k = 0; k < 2; k++) cycle(2'b00, 1'b1, 1'b0);

        // Pointer wrap with continuous write and pop.
        cycle(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin din[0] = 8'(8'h40 + i); cycle(2'b01, 1'b1, 1'b0); end
        for (int k = 0; k < 2; k++) cycle(2'b00, 1'b1, 1'b0);
        check("wrap_rd_ptr", 32'(dut.rd_ptr), 32'd4);
        check("wrap_wr_ptr", 32'(dut.wr_ptr), 32'd4);

        // Pop on empty, then write+pop on empty: no fall-through.
        cycle(2'b00, 1'b1, 1'b0);
        din[0] = 8'hA5;
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        check("a5_pop", 32'(rd_data), 32'hA5);

        // Held full with a waiting producer, then flush.
        for (int i = 0; i < 16; i++) begin din[0] = 8'(i); cycle(2'b01, 1'b0, 1'b0); end
        for (int i = 0; i < 300; i++) cycle(2'b01, 1'b0, 1'b0);
`ifdef CBA_DROP_CNT_EN
        check("drop_sat", 32'(drop_cnt), 32'd255);
`else
        check("drop_off", 32'(drop_cnt), 32'd0);
`endif
        cycle(2'b01, 1'b0, 1'b1);
        check("flush_drop", 32'(drop_cnt), 32'd0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
